// File: rtl/div_issue_ctrl_if.sv
// Control/data bus between the EX-stage divide sequencer (master) and the shared
// multi-cycle divider (slave).
interface div_issue_ctrl_if;
  logic        div_start;
  logic        div_annul;
  logic        div_signed;
  logic [31:0] div_opa;
  logic [31:0] div_opb;
  logic        div_ready;
  logic [63:0] div_result;

  modport master (
    output div_start, div_annul, div_signed, div_opa, div_opb,
    input  div_ready, div_result
  );

  modport slave (
    input  div_start, div_annul, div_signed, div_opa, div_opb,
    output div_ready, div_result
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Sequencer for the shared multi-cycle divider: latches operands, stalls EX, holds the
// {rem,quot} result until retirement, and aborts on flush or watchdog expiry.
// Optional macro DIV_ZERO_BYPASS_EN: a zero divisor skips the divider entirely.
module div_issue_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flushE,
  input  logic                   stallM,
  input  logic                   req_valid,
  input  logic                   req_signed,
  input  logic [31:0]            src_aE,
  input  logic [31:0]            src_bE,
  div_issue_ctrl_if.master       div_bus,
  output logic                   div_stallE,
  output logic [63:0]            result_o,
  output logic                   result_valid,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ABORT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        sgn;
  logic        accept;

  assign accept = req_valid && !flushE;

  // NOTE: every register here uses <= so all of them sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      opa         <= '0;
      opb         <= '0;
      sgn         <= 1'b0;
      result_o    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opa <= src_aE;
            opb <= src_bE;
            sgn <= req_signed;
            cnt <= '0;
`ifdef DIV_ZERO_BYPASS_EN
            if (src_bE == 32'd0) begin
              result_o <= {src_aE, 32'hFFFF_FFFF};
              state    <= DONE;
            end else begin
              state <= BUSY;
            end
`else
            state <= BUSY;
`endif
          end
        end
        BUSY: begin
          // Flush beats a same-cycle answer; the answer beats the watchdog.
          if (flushE) begin
            state <= ABORT;
          end else if (div_bus.div_ready) begin
            result_o <= div_bus.div_result;
            state    <= DONE;
          end else if (cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            state       <= ABORT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          if (flushE || !stallM) state <= IDLE;
        end
        ABORT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign div_bus.div_start  = (state == BUSY) && !rst;
  assign div_bus.div_annul  = rst || (state == ABORT);
  assign div_bus.div_signed = sgn;
  assign div_bus.div_opa    = opa;
  assign div_bus.div_opb    = opb;
  assign result_valid       = (state == DONE) && !rst;

  // NOTE: default assignment first so no path through the case leaves a latch.
  always_comb begin
    div_stallE = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    div_stallE = accept;
        BUSY:    div_stallE = 1'b1;
        default: div_stallE = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: table of divide transactions against a behavioural
// divider, plus hand sequences for reset, abort-retry, stray ready and zero divisor.
module tb_div_issue_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        flushE, stallM, req_valid, req_signed;
  logic [31:0] src_aE, src_bE;
  logic        div_stallE, result_valid, timeout_err;
  logic [63:0] result_o;

  div_issue_ctrl_if bus();

  div_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .flushE(flushE), .stallM(stallM),
    .req_valid(req_valid), .req_signed(req_signed),
    .src_aE(src_aE), .src_bE(src_bE), .div_bus(bus),
    .div_stallE(div_stallE), .result_o(result_o),
    .result_valid(result_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    int          ready_at;   // BUSY cycle the divider answers (0 = never)
    int          flush_at;   // BUSY cycle flushE is raised (0 = never)
    int          stall_cyc;  // DONE cycles with stallM high
    int          exp_busy;
    logic        exp_done;
    logic [63:0] exp_res;
    logic        exp_tmo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural divider: zero divisor yields {dividend, all-ones}.
  function automatic logic [63:0] fake_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) return {32'(sa % sb), 32'(sa / sb)};
    return {a % b, a / b};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic bad;
    step();
    req_valid = 1'b1; src_aE = v.a; src_bE = v.b; req_signed = v.sgn;
    flushE = 1'b0; stallM = 1'b0; bus.div_ready = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_req_stall", idx), div_stallE, 1);
    bad = 1'b0;
    for (int n = 1; n <= v.exp_busy; n++) begin
      step();
      req_valid = 1'b0; src_aE = ~v.a; src_bE = ~v.b; req_signed = ~v.sgn;
      flushE = (n == v.flush_at);
      bus.div_ready = (n == v.ready_at);
      bus.div_result = bus.div_ready ? fake_div(bus.div_opa, bus.div_opb, bus.div_signed)
                                     : 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      if (bus.div_start !== 1'b1 || div_stallE !== 1'b1 || result_valid !== 1'b0 ||
          bus.div_opa !== v.a || bus.div_opb !== v.b || bus.div_signed !== v.sgn)
        bad = 1'b1;
    end
    check($sformatf("v%0d_busy_hold", idx), bad, 0);
    step();
    flushE = 1'b0; bus.div_ready = 1'b0; req_valid = 1'b0;
    if (v.exp_done) begin
      bad = 1'b0;
      for (int d = 0; d <= v.stall_cyc; d++) begin
        if (d > 0) step();
        stallM = (d < v.stall_cyc);
        @(negedge clk);
        if (result_valid !== 1'b1 || result_o !== v.exp_res || div_stallE !== 1'b0 ||
            bus.div_start !== 1'b0)
          bad = 1'b1;
      end
      check($sformatf("v%0d_result", idx), result_o, v.exp_res);
      check($sformatf("v%0d_done_hold", idx), bad, 0);
      step();
      stallM = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_valid_drop", idx), result_valid, 0);
      check($sformatf("v%0d_idle_start", idx), bus.div_start, 0);
    end else begin
      stallM = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_annul_pulse", idx), bus.div_annul, 1);
      check($sformatf("v%0d_abort_valid", idx), result_valid, 0);
      check($sformatf("v%0d_abort_stall", idx), div_stallE, 0);
      step();
      @(negedge clk);
      check($sformatf("v%0d_annul_clear", idx), bus.div_annul, 0);
      check($sformatf("v%0d_idle_valid", idx), result_valid, 0);
    end
    check($sformatf("v%0d_timeout_err", idx), timeout_err, v.exp_tmo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench did not complete");
  end

  initial begin
    vecs[0] = '{a:32'd100,        b:32'd7,          sgn:1'b0, ready_at:33, flush_at:0,
                stall_cyc:0, exp_busy:33, exp_done:1'b1, exp_res:64'h00000002_0000000E, exp_tmo:1'b0};
    vecs[1] = '{a:32'hFFFF_FFF9,  b:32'd2,          sgn:1'b1, ready_at:5,  flush_at:0,
                stall_cyc:0, exp_busy:5,  exp_done:1'b1, exp_res:64'hFFFFFFFF_FFFFFFFD, exp_tmo:1'b0};
    vecs[2] = '{a:32'd50,         b:32'd5,          sgn:1'b0, ready_at:5,  flush_at:5,
                stall_cyc:0, exp_busy:5,  exp_done:1'b0, exp_res:64'h0,                 exp_tmo:1'b0};
    vecs[3] = '{a:32'd9,          b:32'd3,          sgn:1'b0, ready_at:3,  flush_at:0,
                stall_cyc:0, exp_busy:3,  exp_done:1'b1, exp_res:64'h00000000_00000003, exp_tmo:1'b0};
    vecs[4] = '{a:32'hFFFF_FFFF,  b:32'd16,         sgn:1'b0, ready_at:10, flush_at:0,
                stall_cyc:4, exp_busy:10, exp_done:1'b1, exp_res:64'h0000000F_0FFFFFFF, exp_tmo:1'b0};
    vecs[5] = '{a:32'd100,        b:32'hFFFF_FFF9,  sgn:1'b1, ready_at:1,  flush_at:0,
                stall_cyc:1, exp_busy:1,  exp_done:1'b1, exp_res:64'h00000002_FFFFFFF2, exp_tmo:1'b0};
    vecs[6] = '{a:32'd1,          b:32'd1,          sgn:1'b0, ready_at:0,  flush_at:0,
                stall_cyc:0, exp_busy:64, exp_done:1'b0, exp_res:64'h0,                 exp_tmo:1'b1};
    vecs[7] = '{a:32'd20,         b:32'd6,          sgn:1'b0, ready_at:2,  flush_at:0,
                stall_cyc:0, exp_busy:2,  exp_done:1'b1, exp_res:64'h00000002_00000003, exp_tmo:1'b1};

    rst = 1'b1; flushE = 1'b0; stallM = 1'b0; req_valid = 1'b0; req_signed = 1'b0;
    src_aE = '0; src_bE = '0; bus.div_ready = 1'b0; bus.div_result = '0;
    step();
    @(negedge clk);
    check("rst_annul", bus.div_annul, 1);
    check("rst_start", bus.div_start, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_result", result_o, 0);
    check("rst_valid", result_valid, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_opa", bus.div_opa, 0);
    check("rst_annul_off", bus.div_annul, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // A stray ready while idle must not produce a result.
    step();
    bus.div_ready = 1'b1; bus.div_result = 64'h0BAD_0BAD_0BAD_0BAD;
    @(negedge clk);
    check("stray_ready_valid", result_valid, 0);
    step();
    bus.div_ready = 1'b0;
    @(negedge clk);
    check("stray_ready_start", bus.div_start, 0);
    check("stray_ready_result", result_o, 64'h00000002_00000003);

    // A request held through ABORT is only accepted once back in IDLE.
    step();
    req_valid = 1'b1; src_aE = 32'd40; src_bE = 32'd8; req_signed = 1'b0;
    @(negedge clk);
    step();
    req_valid = 1'b0; src_aE = 32'd1; src_bE = 32'd1;
    @(negedge clk);
    step();
    flushE = 1'b1;
    @(negedge clk);
    step();
    flushE = 1'b0; req_valid = 1'b1; src_aE = 32'd40; src_bE = 32'd8;
    @(negedge clk);
    check("abort_annul", bus.div_annul, 1);
    check("abort_no_accept", div_stallE, 0);
    step();
    @(negedge clk);
    check("retry_accept", div_stallE, 1);
    check("retry_idle_start", bus.div_start, 0);
    step();
    req_valid = 1'b0;
    bus.div_ready = 1'b1;
    bus.div_result = fake_div(bus.div_opa, bus.div_opb, bus.div_signed);
    @(negedge clk);
    check("retry_busy_start", bus.div_start, 1);
    check("retry_opa", bus.div_opa, 32'd40);
    step();
    bus.div_ready = 1'b0;
    @(negedge clk);
    check("retry_valid", result_valid, 1);
    check("retry_result", result_o, 64'h00000000_00000005);
    step();
    @(negedge clk);

    // Reset in the middle of BUSY.
    step();
    req_valid = 1'b1; src_aE = 32'd77; src_bE = 32'd3;
    @(negedge clk);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    check("midbusy_start", bus.div_start, 1);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_annul", bus.div_annul, 1);
    check("midrst_start", bus.div_start, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("postrst_start", bus.div_start, 0);
    check("postrst_annul", bus.div_annul, 0);
    check("postrst_valid", result_valid, 0);
    check("postrst_result", result_o, 0);
    check("postrst_tmo", timeout_err, 0);
    check("postrst_opb", bus.div_opb, 0);
    check("postrst_stall", div_stallE, 0);

    // Zero divisor.
    step();
    req_valid = 1'b1; src_aE = 32'h0000_1234; src_bE = 32'd0; req_signed = 1'b0;
    @(negedge clk);
    check("zero_req_stall", div_stallE, 1);
`ifdef DIV_ZERO_BYPASS_EN
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("zero_bypass_start", bus.div_start, 0);
    check("zero_bypass_stall", div_stallE, 0);
`else
    step();
    req_valid = 1'b0;
    bus.div_ready = 1'b1;
    bus.div_result = fake_div(bus.div_opa, bus.div_opb, bus.div_signed);
    @(negedge clk);
    check("zero_busy_start", bus.div_start, 1);
    step();
    bus.div_ready = 1'b0;
    @(negedge clk);
`endif
    check("zero_valid", result_valid, 1);
    check("zero_result", result_o, 64'h00001234_FFFFFFFF);
    step();
    @(negedge clk);
    check("zero_valid_drop", result_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
